// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths and entry type for the register-file write path.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_fwd_match
// Description : Finds the youngest occupied queue entry whose rd matches src.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0]         src_i,
    input  logic [DEPTH*ADDR_W-1:0]   rd_flat_i,
    input  logic [DEPTH*DATA_W-1:0]   data_flat_i,
    input  logic [$clog2(DEPTH)-1:0]  head_i,
    input  logic [$clog2(DEPTH):0]    count_i,
    output logic                      hit_o,
    output logic [DATA_W-1:0]         data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] w_idx;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head_i + PTR_W'(k);
            if ((CNT_W'(k) < count_i) &&
                (rd_flat_i[w_idx*ADDR_W +: ADDR_W] == src_i)) begin
                hit_o  = 1'b1;
                data_o = data_flat_i[w_idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue
// Description : In-order write-back queue feeding the register file write port
//               with rs/rt forwarding from pending entries.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wb_en,
    output logic                     wb_wrt,
    output logic [ADDR_W-1:0]        wb_rd,
    output logic [DATA_W-1:0]        wb_data,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rt,
    output logic                     rs_hit,
    output logic [DATA_W-1:0]        rs_fwd,
    output logic                     rt_hit,
    output logic [DATA_W-1:0]        rt_fwd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]        mem_rd_q   [DEPTH];
    logic [DATA_W-1:0]        mem_data_q [DEPTH];
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic                     w_push;
    logic                     w_pop;
    logic [DEPTH*ADDR_W-1:0]  w_rd_flat;
    logic [DATA_W*DEPTH-1:0]  w_data_flat;

    assign wb_wrt   = (count_q != '0) && wb_en && !rst;
    // A full queue still accepts when its head drains in the same cycle.
    assign in_ready = !rst && ((count_q != CNT_W'(DEPTH)) || wb_wrt);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = wb_wrt;

    assign wb_rd    = mem_rd_q[head_q];
    assign wb_data  = mem_data_q[head_q];
    assign count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_pop) begin
            head_d = head_q + 1'b1;
        end
        if (w_push) begin
            tail_d = tail_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_rd_q[tail_q]   <= in_rd;
            mem_data_q[tail_q] <= in_data;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_flat
            assign w_rd_flat[g*ADDR_W +: ADDR_W]   = mem_rd_q[g];
            assign w_data_flat[g*DATA_W +: DATA_W] = mem_data_q[g];
        end
    endgenerate

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_rs (
        .src_i       (rs),
        .rd_flat_i   (w_rd_flat),
        .data_flat_i (w_data_flat),
        .head_i      (head_q),
        .count_i     (count_q),
        .hit_o       (rs_hit),
        .data_o      (rs_fwd)
    );

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_rt (
        .src_i       (rt),
        .rd_flat_i   (w_rd_flat),
        .data_flat_i (w_data_flat),
        .head_i      (head_q),
        .count_i     (count_q),
        .hit_o       (rt_hit),
        .data_o      (rt_fwd)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_queue
// Description : Directed plus random stimulus against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              wb_en;
    logic              wb_wrt;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              rs_hit;
    logic [DATA_W-1:0] rs_fwd;
    logic              rt_hit;
    logic [DATA_W-1:0] rt_fwd;
    logic [2:0]        count;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b1;

    wb_entry_t         mq[$];
    logic [DATA_W-1:0] mrf [NUM_REGS];
    logic [DATA_W-1:0] rf  [NUM_REGS];

    regfile_wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .wb_en(wb_en), .wb_wrt(wb_wrt), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs(rs), .rt(rt),
        .rs_hit(rs_hit), .rs_fwd(rs_fwd), .rt_hit(rt_hit), .rt_fwd(rt_fwd),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void mfwd(input logic [ADDR_W-1:0] s, output logic h,
                                 output logic [DATA_W-1:0] d);
        h = 1'b0;
        d = '0;
        foreach (mq[i]) begin
            if (mq[i].rd == s) begin
                h = 1'b1;
                d = mq[i].data;
            end
        end
    endfunction

    // One clock: drive in the low phase, check, let the posedge happen, update model.
    task automatic cycle(input bit r, input bit v, input logic [ADDR_W-1:0] d_rd,
                         input logic [DATA_W-1:0] d_data, input bit en,
                         input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] t);
        bit exp_wrt, exp_rdy, exp_full;
        logic h;
        logic [DATA_W-1:0] fd;
        rst = r; in_valid = v; in_rd = d_rd; in_data = d_data;
        wb_en = en; rs = s; rt = t;
        #1;
        exp_wrt  = (mq.size() != 0) && en && !r;
        exp_full = (mq.size() == DEPTH);
        exp_rdy  = !r && (!exp_full || exp_wrt);
        chk("wb_wrt", {31'b0, wb_wrt}, {31'b0, exp_wrt});
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        if (check_en) begin
            chk("count", {29'b0, count}, mq.size());
            if (exp_wrt) begin
                chk("wb_rd", {26'b0, wb_rd}, {26'b0, mq[0].rd});
                chk("wb_data", wb_data, mq[0].data);
            end
            mfwd(s, h, fd);
            chk("rs_hit", {31'b0, rs_hit}, {31'b0, h});
            chk("rs_fwd", rs_fwd, fd);
            mfwd(t, h, fd);
            chk("rt_hit", {31'b0, rt_hit}, {31'b0, h});
            chk("rt_fwd", rt_fwd, fd);
        end
        if (wb_wrt === 1'b1) rf[wb_rd] = wb_data;
        @(posedge clk);
        if (r) begin
            mq.delete();
        end else begin
            if (exp_wrt) begin
                mrf[mq[0].rd] = mq[0].data;
                void'(mq.pop_front());
            end
            if (v && exp_rdy) mq.push_back('{rd: d_rd, data: d_data});
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rf[i] = '0;
            mrf[i] = '0;
        end

        // Reset with a producer already asserting.
        check_en = 1'b0;
        cycle(1, 1, 6'd3, 32'h1, 1, 0, 0);
        check_en = 1'b1;
        cycle(1, 1, 6'd3, 32'h1, 1, 0, 0);
        cycle(0, 0, 6'd0, 32'h0, 1, 0, 0);

        // Single write: visible as the head right after the push edge.
        cycle(0, 1, 6'd5, 32'hDEADBEEF, 1, 6'd5, 0);
        cycle(0, 0, 6'd0, 32'h0, 1, 6'd5, 0);
        chk("rf5", rf[5], 32'hDEADBEEF);
        cycle(0, 0, 6'd0, 32'h0, 1, 0, 0);

        // Fill, hold the fifth, then simultaneous push/pop while full.
        for (int i = 1; i <= 4; i++)
            cycle(0, 1, 6'(i), 32'(i * 32'h11), 0, 6'd2, 6'd4);
        cycle(0, 1, 6'd6, 32'h66, 0, 6'd6, 6'd1);
        cycle(0, 1, 6'd6, 32'h66, 1, 6'd6, 6'd1);
        chk("full_count", {29'b0, count}, 32'd4);
        for (int i = 0; i < 6; i++) cycle(0, 0, 6'd0, 32'h0, 1, 6'd6, 6'd3);
        chk("rf6", rf[6], 32'h66);

        // Forwarding picks the youngest match.
        cycle(0, 1, 6'd7, 32'h1, 0, 6'd7, 6'd9);
        cycle(0, 1, 6'd7, 32'h2, 0, 6'd7, 6'd9);
        cycle(0, 1, 6'd9, 32'h3, 0, 6'd7, 6'd9);
        cycle(0, 0, 6'd0, 32'h0, 0, 6'd7, 6'd9);
        chk("rs_fwd_young", rs_fwd, 32'h2);
        cycle(0, 0, 6'd0, 32'h0, 0, 6'd8, 6'd9);
        chk("rs_miss", {31'b0, rs_hit}, 32'd0);

        // Reset mid-operation discards the three pending entries.
        cycle(1, 0, 6'd0, 32'h0, 0, 6'd7, 6'd9);
        for (int i = 0; i < 3; i++) cycle(0, 0, 6'd0, 32'h0, 1, 6'd7, 6'd9);
        chk("rf7_untouched", rf[7], 32'h0);

        // Back-to-back push/pop across pointer wrap.
        for (int i = 0; i < 10; i++)
            cycle(0, 1, 6'(i + 10), 32'(i * 32'h100), 1, 6'(i + 9), 6'(i + 10));
        cycle(0, 0, 6'd0, 32'h0, 1, 0, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                  6'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 3) != 0),
                  6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)));
        for (int i = 0; i < 6; i++) cycle(0, 0, 6'd0, 32'h0, 1, 0, 0);

        for (int i = 0; i < NUM_REGS; i++) chk($sformatf("rf[%0d]", i), rf[i], mrf[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
